// File: rtl/uart_rx_cfg.sv
// Purpose : configurable UART receiver (5..9 data bits, none/odd/even parity,
//           1 or 2 stop bits) with 3-sample mid-bit majority voting.
// Latency : o_Rx_DV fires H+2 cycles into the last stop bit; no backpressure.
// Ports   : i_Clock/i_Reset (async active-high), i_Rx_Serial (idles high),
//           o_Rx_DV strobe with o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break
//           held until the next strobe.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int H  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HM1  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(H);
  localparam logic [CW-1:0] CNT_HP1  = CW'(H + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP       = 3'd4,
    S_BREAK_WAIT = 3'd5,
    S_CLEANUP    = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q;
  logic [1:0]             fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [1:0]             smp_q, smp_d;
  logic                   maj_q, maj_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   par_acc_q, par_acc_d;
  logic                   par_err_q, par_err_d;
  logic                   any_one_q, any_one_d;
  logic                   stop_bad_q, stop_bad_d;
  logic                   rx_dv_q, rx_dv_d;
  logic [DATA_BITS-1:0]   rx_byte_q, rx_byte_d;
  logic                   par_err_out_q, par_err_out_d;
  logic                   frame_err_q, frame_err_d;
  logic                   break_q, break_d;

  // Helper terms shared by the next-state and datapath logic.
  logic          maj_now;
  logic          cnt_wrap;
  logic [CW-1:0] cnt_next;
  logic          last_stop;
  logic          last_stop_end;
  logic          brk_now;
  logic          frame_now;
  logic          par_xor;

  // Majority of the samples taken at H-1 and H plus the live sample at H+1.
  assign maj_now  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);
  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign cnt_next = cnt_wrap ? '0 : cnt_q + CW'(1);
  assign last_stop     = (stop_idx_q == STOP_LAST);
  assign last_stop_end = (state_q == S_STOP) && last_stop && (cnt_q == CNT_HP1);
  // Break: nothing but zeros from the first data bit through the last stop bit.
  assign brk_now   = !any_one_q && !maj_now;
  assign frame_now = stop_bad_q || !maj_now;
  assign par_xor   = par_acc_q ^ maj_q;

  // ------------------------------------------------------------------
  // State / datapath register
  // ------------------------------------------------------------------
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      fill_q        <= '0;
      armed_q       <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      stop_idx_q    <= 1'b0;
      smp_q         <= '0;
      maj_q         <= 1'b0;
      data_q        <= '0;
      par_acc_q     <= 1'b0;
      par_err_q     <= 1'b0;
      any_one_q     <= 1'b0;
      stop_bad_q    <= 1'b0;
      rx_dv_q       <= 1'b0;
      rx_byte_q     <= '0;
      par_err_out_q <= 1'b0;
      frame_err_q   <= 1'b0;
      break_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= i_Rx_Serial;
      rx_sync_q     <= rx_meta_q;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stop_idx_q    <= stop_idx_d;
      smp_q         <= smp_d;
      maj_q         <= maj_d;
      data_q        <= data_d;
      par_acc_q     <= par_acc_d;
      par_err_q     <= par_err_d;
      any_one_q     <= any_one_d;
      stop_bad_q    <= stop_bad_d;
      rx_dv_q       <= rx_dv_d;
      rx_byte_q     <= rx_byte_d;
      par_err_out_q <= par_err_out_d;
      frame_err_q   <= frame_err_d;
      break_q       <= break_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (armed_q && !rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if ((cnt_q == CNT_HP1) && maj_now) state_d = S_IDLE;   // false start
        else if (cnt_wrap)                 state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_wrap && (idx_q == IDX_LAST))
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (cnt_wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (last_stop_end) state_d = brk_now ? S_BREAK_WAIT : S_CLEANUP;
      end
      S_BREAK_WAIT: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      S_CLEANUP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Counters, sampling, word assembly and output registers
  // ------------------------------------------------------------------
  always_comb begin
    fill_d        = {fill_q[0], 1'b1};
    // The synchroniser resets to 1, so its reset value must not arm the
    // receiver: only a high level that actually came through both flops does.
    armed_d       = armed_q | (fill_q[1] & rx_sync_q);
    cnt_d         = '0;
    idx_d         = idx_q;
    stop_idx_d    = stop_idx_q;
    smp_d         = smp_q;
    maj_d         = maj_q;
    data_d        = data_q;
    par_acc_d     = par_acc_q;
    par_err_d     = par_err_q;
    any_one_d     = any_one_q;
    stop_bad_d    = stop_bad_q;
    rx_dv_d       = 1'b0;
    rx_byte_d     = rx_byte_q;
    par_err_out_d = par_err_out_q;
    frame_err_d   = frame_err_q;
    break_d       = break_q;

    if (cnt_q == CNT_HM1) smp_d[0] = rx_sync_q;
    if (cnt_q == CNT_H)   smp_d[1] = rx_sync_q;
    if (cnt_q == CNT_HP1) maj_d    = maj_now;

    case (state_q)
      S_IDLE: begin
        // Per-frame accumulators start clean for the next start bit.
        idx_d      = '0;
        stop_idx_d = 1'b0;
        par_acc_d  = 1'b0;
        par_err_d  = 1'b0;
        any_one_d  = 1'b0;
        stop_bad_d = 1'b0;
      end
      S_START: begin
        cnt_d = cnt_next;
        if ((cnt_q == CNT_HP1) && maj_now) cnt_d = '0;
      end
      S_DATA: begin
        cnt_d = cnt_next;
        if (cnt_wrap) begin
          data_d[idx_q] = maj_q;
          par_acc_d     = par_acc_q ^ maj_q;
          any_one_d     = any_one_q | maj_q;
          idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
      S_PARITY: begin
        cnt_d = cnt_next;
        if (cnt_wrap) begin
          // Odd parity expects an XOR of 1 over data+parity, even expects 0.
          par_err_d = (PARITY == 1) ? ~par_xor : par_xor;
          any_one_d = any_one_q | maj_q;
        end
      end
      S_STOP: begin
        cnt_d = cnt_next;
        if (!last_stop && cnt_wrap) begin
          stop_bad_d = stop_bad_q | ~maj_q;
          any_one_d  = any_one_q | maj_q;
          stop_idx_d = 1'b1;
        end
        // The last stop bit closes at H+1 so the next start edge is caught early.
        if (last_stop_end) begin
          cnt_d         = '0;
          rx_dv_d       = 1'b1;
          rx_byte_d     = brk_now ? '0 : data_q;
          par_err_out_d = (PARITY != 0) && par_err_q;
          frame_err_d   = frame_now;
          break_d       = brk_now;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign o_Rx_DV      = rx_dv_q;
  assign o_Rx_Byte    = rx_byte_q;
  assign o_Parity_Err = par_err_out_q;
  assign o_Frame_Err  = frame_err_q;
  assign o_Break      = break_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Purpose : bench for uart_rx_cfg with three instances (8N1, 8E1, 8N2) at 16
//           clocks per bit, checked against a frame-level model every cycle.
// Latency : expected strobe = line fall + 3 + (bits before last stop)*16 + 9.
// Ports   : all DUT ports connected; no backpressure exists on this block.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  typedef struct {
    int unsigned cyc;
    int          inst;
    logic [7:0]  byt;
    logic        pe;
    logic        fe;
    logic        brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx   [3];
  logic       dv   [3];
  logic [7:0] byt  [3];
  logic       pe   [3];
  logic       fe   [3];
  logic       brk  [3];

  logic [7:0] hold_b  [3];
  logic       hold_pe [3];
  logic       hold_fe [3];
  logic       hold_bk [3];
  int unsigned dv_cnt  [3];
  int unsigned last_dv [3];

  exp_t        expq[$];
  exp_t        e_cur;
  int unsigned cyc = 0;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]),
    .o_Rx_Byte(byt[0]), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(brk[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]),
    .o_Rx_Byte(byt[1]), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(brk[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]),
    .o_Rx_Byte(byt[2]), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(brk[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Frame levels per bit slot: slot 0 start, 1..8 data LSB first, then the
  // parity bit (8E1 only) and stop bit(s); slots past the frame idle high.
  function automatic logic [15:0] mkframe(input int inst, input logic [7:0] d,
                                          input logic pbit, input logic s2);
    logic [15:0] lv;
    lv      = 16'hFFFF;
    lv[0]   = 1'b0;
    lv[8:1] = d;
    if (inst == 1) lv[9] = pbit;
    if (inst == 2) lv[10] = s2;
    return lv;
  endfunction

  // Frame-level expectation derived from the bit levels on the line.
  function automatic exp_t model(input int inst, input logic [15:0] lv, input int unsigned c0);
    exp_t       e;
    int         np, ns, n;
    logic [7:0] d;
    np = (inst == 1) ? 1 : 0;
    ns = (inst == 2) ? 2 : 1;
    n  = 1 + 8 + np + ns;
    d  = lv[8:1];
    e.inst = inst;
    e.pe   = (np == 1) && ((^d ^ lv[9]) == 1'b1);
    e.fe   = 1'b0;
    e.brk  = 1'b1;
    for (int s = 1; s < n; s++) if (lv[s]) e.brk = 1'b0;
    for (int s = n - ns; s < n; s++) if (!lv[s]) e.fe = 1'b1;
    if (e.brk) begin
      d    = 8'h00;
      e.fe = 1'b1;
    end
    e.byt = d;
    e.cyc = c0 + 3 + (n - 1) * CPB + (CPB - 1) / 2 + 2;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives nslots bit times; glitch is a line-cycle index to invert (or -1).
  task automatic send(input int inst, input logic [15:0] lv, input int nslots,
                      input int glitch, input bit expect_it, output int unsigned c0);
    c0 = cyc;
    if (expect_it) expq.push_back(model(inst, lv, c0));
    for (int s = 0; s < nslots; s++) begin
      for (int c = 0; c < CPB; c++) begin
        rx[inst] = ((s * CPB + c) == glitch) ? ~lv[s] : lv[s];
        @(posedge clk);
        #1;
      end
    end
    rx[inst] = 1'b1;
  endtask

  task automatic clear_model();
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      hold_b[i]  = 8'h00;
      hold_pe[i] = 1'b0;
      hold_fe[i] = 1'b0;
      hold_bk[i] = 1'b0;
    end
  endtask

  // Compare process: strobes against the model queue, held outputs otherwise.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] === 1'b1) begin
        dv_cnt[i]++;
        last_dv[i] = cyc;
        if (expq.size() > 0 && expq[0].inst == i) begin
          e_cur = expq.pop_front();
          chk($sformatf("strobe_cycle[%0d]", i), cyc, e_cur.cyc);
          chk($sformatf("byte[%0d]", i), {24'd0, byt[i]}, {24'd0, e_cur.byt});
          chk($sformatf("flags_pe_fe_brk[%0d]", i), {29'd0, pe[i], fe[i], brk[i]},
              {29'd0, e_cur.pe, e_cur.fe, e_cur.brk});
          hold_b[i]  = e_cur.byt;
          hold_pe[i] = e_cur.pe;
          hold_fe[i] = e_cur.fe;
          hold_bk[i] = e_cur.brk;
        end else begin
          chk($sformatf("unexpected_strobe[%0d]", i), 32'd1, 32'd0);
        end
      end else begin
        chk($sformatf("held_outputs[%0d]", i), {21'd0, dv[i], byt[i], pe[i], fe[i], brk[i]},
            {21'd0, 1'b0, hold_b[i], hold_pe[i], hold_fe[i], hold_bk[i]});
      end
    end
    if (expq.size() > 0 && cyc > expq[0].cyc) begin
      e_cur = expq.pop_front();
      chk($sformatf("missed_strobe[%0d]", e_cur.inst), cyc, e_cur.cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int unsigned c0;
    int unsigned n0;
    logic [15:0] lv;
    for (int i = 0; i < 3; i++) begin
      rx[i]      = 1'b1;
      dv_cnt[i]  = 0;
      last_dv[i] = 0;
    end
    clear_model();
    rst = 1'b1;
    idle(4);
    chk("reset_outputs", {20'd0, dv[0], byt[0], pe[0], fe[0], brk[0], dv[1], fe[2]}, 32'd0);
    rst = 1'b0;
    idle(20);

    // 8N1 nominal plus a back-to-back second frame.
    send(0, mkframe(0, 8'hA5, 1'b0, 1'b1), 10, -1, 1'b1, c0);
    chk("a5_latency", last_dv[0] - (c0 + 3), 32'd153);
    chk("a5_byte", {24'd0, byt[0]}, 32'hA5);
    chk("a5_flags", {29'd0, pe[0], fe[0], brk[0]}, 32'd0);
    send(0, mkframe(0, 8'h3C, 1'b0, 1'b1), 10, -1, 1'b1, c0);
    chk("b2b_3c_byte", {24'd0, byt[0]}, 32'h3C);
    idle(30);

    // 8E1: 0x37 has five ones, so the correct even-parity bit is 1.
    send(1, mkframe(1, 8'h37, 1'b0, 1'b1), 11, -1, 1'b1, c0);
    chk("par_bad_latency", last_dv[1] - (c0 + 3), 32'd169);
    chk("par_bad_pe", {31'd0, pe[1]}, 32'd1);
    chk("par_bad_fe", {31'd0, fe[1]}, 32'd0);
    chk("par_bad_byte", {24'd0, byt[1]}, 32'h37);
    idle(30);
    send(1, mkframe(1, 8'h37, 1'b1, 1'b1), 11, -1, 1'b1, c0);
    chk("par_ok_pe", {31'd0, pe[1]}, 32'd0);
    idle(30);

    // 8N2 with the second stop bit low.
    send(2, mkframe(2, 8'h55, 1'b0, 1'b0), 11, -1, 1'b1, c0);
    chk("frame_err_fe", {31'd0, fe[2]}, 32'd1);
    chk("frame_err_byte", {24'd0, byt[2]}, 32'h55);
    idle(40);

    // False start: 5-cycle low pulse, then a valid frame.
    n0 = dv_cnt[0];
    rx[0] = 1'b0;
    idle(5);
    rx[0] = 1'b1;
    idle(40);
    chk("false_start_no_strobe", dv_cnt[0] - n0, 32'd0);
    send(0, mkframe(0, 8'h81, 1'b0, 1'b1), 10, -1, 1'b1, c0);
    chk("after_fs_byte", {24'd0, byt[0]}, 32'h81);
    idle(30);

    // Single-cycle glitch in the middle of data bit 3 of 0x00 (line cycle 4*16+8).
    send(0, mkframe(0, 8'h00, 1'b0, 1'b1), 10, 4 * CPB + 8, 1'b1, c0);
    chk("glitch_byte", {24'd0, byt[0]}, 32'h00);
    idle(30);

    // Break: line low for 12 bit times, then high.
    n0 = dv_cnt[0];
    lv = 16'h0000;
    send(0, lv, 12, -1, 1'b1, c0);
    idle(60);
    chk("break_strobe_count", dv_cnt[0] - n0, 32'd1);
    chk("break_flags", {29'd0, pe[0], fe[0], brk[0]}, 32'b011);
    chk("break_byte", {24'd0, byt[0]}, 32'h00);

    // Reset during data bit 4 of 0x66 (line cycle 88), line held low afterwards.
    lv = mkframe(0, 8'h66, 1'b0, 1'b1);
    n0 = dv_cnt[0];
    for (int j = 0; j < 88; j++) begin
      rx[0] = lv[j / CPB];
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    clear_model();
    #1;
    chk("midreset_outputs", {20'd0, dv[0], byt[0], pe[0], fe[0], brk[0], 2'b00}, 32'd0);
    idle(3);
    rst = 1'b0;
    rx[0] = 1'b0;
    idle(3 * CPB);
    rx[0] = 1'b1;
    idle(40);
    chk("midreset_no_strobe", dv_cnt[0] - n0, 32'd0);
    send(0, mkframe(0, 8'h5A, 1'b0, 1'b1), 10, -1, 1'b1, c0);
    chk("after_reset_byte", {24'd0, byt[0]}, 32'h5A);
    idle(30);

    chk("model_queue_drained", expq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
